// File: rtl/brr_ram_arbiter.sv
// Audio RAM port arbiter: CPU plus NUM_VOICES BRR voices, one access per cycle,
// reads tagged through the two-stage RAM return path back to their requester.

module brr_voice_slot (
  input  logic clock,
  input  logic reset,
  input  logic grant_set,
  input  logic ret_hit,
  output logic grant,
  output logic data_valid
);
  always_ff @(posedge clock) begin
    if (reset) begin
      grant      <= 1'b0;
      data_valid <= 1'b0;
    end else begin
      grant      <= grant_set;
      data_valid <= ret_hit;
    end
  end
endmodule

module brr_ram_arbiter #(
  parameter int NUM_VOICES     = 8,
  parameter int ADDR_WIDTH     = 16,
  parameter int MAX_CPU_STREAK = 4
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NUM_VOICES-1:0]            voice_req,
  input  logic [NUM_VOICES*ADDR_WIDTH-1:0] voice_addr,
  output logic [NUM_VOICES-1:0]            voice_grant,
  output logic [NUM_VOICES-1:0]            voice_data_valid,
  input  logic                             cpu_req,
  input  logic                             cpu_we,
  input  logic [ADDR_WIDTH-1:0]            cpu_addr,
  input  logic [7:0]                       cpu_wdata,
  output logic                             cpu_grant,
  output logic                             cpu_data_valid,
  output logic [7:0]                       read_data,
  output logic [ADDR_WIDTH-1:0]            ram_address,
  output logic                             ram_read_request,
  output logic                             ram_write_request,
  output logic [7:0]                       ram_wdata,
  input  logic [7:0]                       ram_data
);
  localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int SW = $clog2(MAX_CPU_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_CPU_STREAK);

  typedef struct packed {
    logic          is_cpu;
    logic [IW-1:0] voice;
  } tag_t;

  logic [IW-1:0]         rr_pointer;
  logic [SW-1:0]         cpu_streak;
  logic [2:1]            vld_pipe;
  tag_t                  tag_s1, tag_s2;

  logic                  any_voice, cpu_win, voice_found, voice_win;
  logic [IW-1:0]         scan_idx, win_idx;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [NUM_VOICES-1:0] grant_set, ret_hit;

  // Round-robin scan starting at rr_pointer; power-of-two count lets the index wrap naturally.
  always_comb begin
    any_voice   = |voice_req;
    cpu_win     = cpu_req && (!any_voice || (cpu_streak < STREAK_MAX));
    voice_found = 1'b0;
    win_idx     = '0;
    scan_idx    = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      scan_idx = rr_pointer + IW'(i);
      if (!voice_found && voice_req[scan_idx]) begin
        voice_found = 1'b1;
        win_idx     = scan_idx;
      end
    end
    win_addr  = voice_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
    voice_win = voice_found && !cpu_win;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_pointer        <= '0;
      cpu_streak        <= '0;
      vld_pipe          <= '0;
      tag_s1            <= '0;
      tag_s2            <= '0;
      cpu_grant         <= 1'b0;
      cpu_data_valid    <= 1'b0;
      read_data         <= '0;
      ram_address       <= '0;
      ram_read_request  <= 1'b0;
      ram_write_request <= 1'b0;
      ram_wdata         <= '0;
    end else begin
      cpu_grant         <= 1'b0;
      ram_read_request  <= 1'b0;
      ram_write_request <= 1'b0;
      vld_pipe[1]       <= 1'b0;
      if (cpu_win) begin
        cpu_grant         <= 1'b1;
        ram_address       <= cpu_addr;
        ram_read_request  <= !cpu_we;
        ram_write_request <= cpu_we;
        if (cpu_we) ram_wdata <= cpu_wdata;
        vld_pipe[1]       <= !cpu_we;
        tag_s1            <= '{is_cpu: 1'b1, voice: '0};
        if (!any_voice)                    cpu_streak <= '0;
        else if (cpu_streak != STREAK_MAX) cpu_streak <= cpu_streak + 1'b1;
      end else if (voice_win) begin
        ram_address      <= win_addr;
        ram_read_request <= 1'b1;
        vld_pipe[1]      <= 1'b1;
        tag_s1           <= '{is_cpu: 1'b0, voice: win_idx};
        rr_pointer       <= win_idx + 1'b1;
        cpu_streak       <= '0;
      end
      // RAM samples at the next edge; its data is captured one edge after that.
      vld_pipe[2]    <= vld_pipe[1];
      tag_s2         <= tag_s1;
      cpu_data_valid <= vld_pipe[2] && tag_s2.is_cpu;
      if (vld_pipe[2]) read_data <= ram_data;
    end
  end

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
    assign grant_set[g] = voice_win && (win_idx == IW'(g));
    assign ret_hit[g]   = vld_pipe[2] && !tag_s2.is_cpu && (tag_s2.voice == IW'(g));
    brr_voice_slot u_slot (
      .clock      (clock),
      .reset      (reset),
      .grant_set  (grant_set[g]),
      .ret_hit    (ret_hit[g]),
      .grant      (voice_grant[g]),
      .data_valid (voice_data_valid[g])
    );
  end
endmodule

// File: tb/tb_brr_ram_arbiter.sv
// Directed bench for brr_ram_arbiter: transaction-level model checked every cycle,
// plus literal expectations for the headline scenarios.

module tb_brr_ram_arbiter;
  localparam int N  = 8;
  localparam int AW = 16;
  localparam int MS = 4;
  localparam int CPU_ID = 100;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  voice_req = '0;
  logic [N*AW-1:0] voice_addr = '0;
  logic [N-1:0]  voice_grant, voice_data_valid;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [7:0]    cpu_wdata = '0;
  logic          cpu_grant, cpu_data_valid;
  logic [7:0]    read_data;
  logic [AW-1:0] ram_address;
  logic          ram_read_request, ram_write_request;
  logic [7:0]    ram_wdata;
  logic [7:0]    ram_data = '0;

  brr_ram_arbiter #(.NUM_VOICES(N), .ADDR_WIDTH(AW), .MAX_CPU_STREAK(MS)) dut (
    .clock(clock), .reset(reset),
    .voice_req(voice_req), .voice_addr(voice_addr),
    .voice_grant(voice_grant), .voice_data_valid(voice_data_valid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_grant(cpu_grant), .cpu_data_valid(cpu_data_valid), .read_data(read_data),
    .ram_address(ram_address), .ram_read_request(ram_read_request),
    .ram_write_request(ram_write_request), .ram_wdata(ram_wdata), .ram_data(ram_data)
  );

  always #5 clock = ~clock;

  int n_cmp = 0, n_bad = 0;
  bit chk_en = 0;
  int glog[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // RAM behaviour: write lands at the sampling edge, read data appears after it.
  logic [7:0] mem  [0:65535];
  logic [7:0] mmem [0:65535];
  always @(posedge clock) begin
    if (ram_write_request) mem[ram_address] = ram_wdata;
    if (ram_read_request)  ram_data <= mem[ram_address];
  end

  // Transaction model: who wins this edge, and what each requester sees later.
  int         m_rr = 0, m_streak = 0;
  logic [N-1:0] m_vg = '0, m_vdv = '0;
  logic       m_cg = 0, m_cdv = 0, m_rd = 0, m_wr = 0;
  logic [AW-1:0] m_addr = '0;
  logic [7:0] m_wdata = '0, m_rdata = '0;
  bit   r1_v = 0, r2_v = 0, r1_cpu = 0, r2_cpu = 0;
  int   r1_who = 0, r2_who = 0;
  logic [7:0] r1_data = '0, r2_data = '0;

  always @(posedge clock) begin
    if (reset) begin
      m_rr = 0; m_streak = 0; m_vg = '0; m_cg = 0; m_rd = 0; m_wr = 0;
      m_addr = '0; m_wdata = '0; m_rdata = '0; m_vdv = '0; m_cdv = 0;
      r1_v = 0; r2_v = 0;
    end else begin
      bit any;
      int k;
      m_vdv = '0; m_cdv = 0;
      if (r2_v) begin
        m_rdata = r2_data;
        if (r2_cpu) m_cdv = 1; else m_vdv[r2_who] = 1'b1;
      end
      r2_v = r1_v; r2_cpu = r1_cpu; r2_who = r1_who; r2_data = r1_data;
      r1_v = 0; m_vg = '0; m_cg = 0; m_rd = 0; m_wr = 0;
      any = (voice_req != 0);
      if (cpu_req && (!any || m_streak < MS)) begin
        m_cg = 1; m_addr = cpu_addr;
        if (cpu_we) begin
          m_wr = 1; m_wdata = cpu_wdata; mmem[cpu_addr] = cpu_wdata;
        end else begin
          m_rd = 1; r1_v = 1; r1_cpu = 1; r1_data = mmem[cpu_addr];
        end
        m_streak = any ? ((m_streak < MS) ? m_streak + 1 : MS) : 0;
      end else if (any) begin
        k = -1;
        for (int i = 0; i < N; i++)
          if (k < 0 && voice_req[(m_rr + i) % N]) k = (m_rr + i) % N;
        m_vg[k] = 1'b1; m_rd = 1; m_addr = voice_addr[k*AW +: AW];
        r1_v = 1; r1_cpu = 0; r1_who = k; r1_data = mmem[m_addr];
        m_rr = (k + 1) % N; m_streak = 0;
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("voice_grant", voice_grant, m_vg);
      chk("cpu_grant", cpu_grant, m_cg);
      chk("ram_read_request", ram_read_request, m_rd);
      chk("ram_write_request", ram_write_request, m_wr);
      if (m_rd || m_wr) chk("ram_address", ram_address, m_addr);
      if (m_wr) chk("ram_wdata", ram_wdata, m_wdata);
      chk("voice_data_valid", voice_data_valid, m_vdv);
      chk("cpu_data_valid", cpu_data_valid, m_cdv);
      chk("read_data", read_data, m_rdata);
      if (cpu_grant) glog.push_back(CPU_ID);
      for (int i = 0; i < N; i++) if (voice_grant[i]) glog.push_back(i);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1; voice_req = '0; cpu_req = 1'b0;
    cyc(2);
    reset = 1'b0;
  endtask

  task automatic chk_log(input string nm, input int exp[$]);
    chk({nm, "_len"}, glog.size(), exp.size());
    for (int i = 0; i < exp.size() && i < glog.size(); i++)
      chk(nm, glog[i], exp[i]);
    glog.delete();
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) begin
      mem[a]  = 8'(a) ^ 8'(a >> 8) ^ 8'h5A;
      mmem[a] = mem[a];
    end
    mem[16'h1234] = 8'hA5; mmem[16'h1234] = 8'hA5;
    for (int i = 0; i < N; i++) voice_addr[i*AW +: AW] = AW'(16'h0300 + 16'h0111 * i);

    // reset then idle
    cyc(1);
    chk_en = 1;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      cyc(1);
      chk("idle_outs", {voice_grant, voice_data_valid, cpu_grant, cpu_data_valid,
                        ram_read_request, ram_write_request}, '0);
    end

    // reset while voice-3 read in flight
    voice_req = 8'h08;
    cyc(1);
    chk("v3_grant", voice_grant, 8'h08);
    voice_req = '0; reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      cyc(1);
      chk("v3_no_valid", voice_data_valid, 8'h00);
    end

    // single read, voice 2
    voice_addr[2*AW +: AW] = 16'h1234;
    voice_req = 8'h04;
    cyc(1);
    voice_req = '0;
    voice_addr[2*AW +: AW] = 16'hFFFF;
    chk("v2_grant", voice_grant, 8'h04);
    chk("v2_addr", ram_address, 16'h1234);
    chk("v2_rdreq", ram_read_request, 1'b1);
    cyc(1);
    chk("v2_grant_pulse", voice_grant, 8'h00);
    cyc(1);
    chk("v2_valid", voice_data_valid, 8'h04);
    chk("v2_data", read_data, 8'hA5);
    cyc(1);
    chk("v2_hold", read_data, 8'hA5);

    // CPU write then read of 0x00F0
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h00F0; cpu_wdata = 8'h7E;
    cyc(1);
    chk("cw_grant", cpu_grant, 1'b1);
    chk("cw_wr", {ram_write_request, ram_read_request}, 2'b10);
    chk("cw_wdata", ram_wdata, 8'h7E);
    cpu_we = 0; cpu_wdata = 8'h00;
    cyc(1);
    cpu_req = 0;
    chk("cr_rd", {ram_write_request, ram_read_request}, 2'b01);
    cyc(1);
    chk("cw_no_valid", cpu_data_valid, 1'b0);
    cyc(1);
    chk("cr_valid", cpu_data_valid, 1'b1);
    chk("cr_data", read_data, 8'h7E);
    cyc(3);

    // rotation from a fresh pointer
    do_reset();
    glog.delete();
    voice_req = '1;
    cyc(9);
    voice_req = '0;
    cyc(4);
    chk_log("rotation", '{0, 1, 2, 3, 4, 5, 6, 7, 0});

    // CPU streak against voice 5, then CPU alone
    cpu_req = 1; voice_req = 8'h20;
    cyc(10);
    voice_req = '0;
    cyc(6);
    cpu_req = 0;
    cyc(4);
    chk_log("streak", '{CPU_ID, CPU_ID, CPU_ID, CPU_ID, 5, CPU_ID, CPU_ID, CPU_ID, CPU_ID, 5,
                        CPU_ID, CPU_ID, CPU_ID, CPU_ID, CPU_ID, CPU_ID});

    // pointer wrap: grant 6 to land pointer on 7, then 0 and 7 together
    voice_req = 8'h40;
    cyc(1);
    voice_req = 8'h81;
    cyc(2);
    voice_req = '0;
    cyc(4);
    chk_log("wrap", '{6, 7, 0});

    cyc(2);
    $display("test done: total=%0d bad=%0d", n_cmp, n_bad);
    $finish;
  end
endmodule
